// File: rtl/decode_stage.sv
// Instruction decode stage: register file with write-through bypass, hazard
// detection against the instruction in ID/EX, and the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN  = 128,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [24:0]     instrIF,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [24:0]     instructionID,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rs3,
  output logic [XLEN-1:0] rd,
  output logic [2:0]      forward,
  output logic            id_valid
);

  // Handshake: instrIF transfers on a rising edge where instr_valid && instr_ready.
  // instr_ready is combinational from instrIF and ID/EX state only (plus rst),
  // and drops for one cycle when two or more read slots hit the in-flight rd.
  localparam logic [24:0] BUBBLE = 25'h1800000;

  logic [XLEN-1:0] regs [NREGS];

  logic            is_li;
  logic            is_r4;
  logic            is_r3;
  logic            in_nop;
  logic            reads_rs12;
  logic            id_nop;
  logic            dest_valid;
  logic [4:0]      dest;
  logic [4:0]      rd_addr [4];
  logic [XLEN-1:0] rd_val  [4];
  logic [3:0]      slot_use;
  logic [3:0]      slot_hit;
  logic [2:0]      hazard_cnt;
  logic [2:0]      fwd_sel;
  logic            stall;
  logic            accept;

  // Decode of the incoming word; slot order is rs1, rs2, rs3, rd.
  assign is_li      = ~instrIF[24];
  assign is_r4      = (instrIF[24:23] == 2'b10);
  assign is_r3      = (instrIF[24:23] == 2'b11);
  assign in_nop     = is_r3 && (instrIF[22:15] == 8'd0);
  assign reads_rs12 = is_r4 || (is_r3 && !in_nop);
  assign slot_use   = {is_li, is_r4, reads_rs12, reads_rs12};

  assign rd_addr[0] = instrIF[9:5];
  assign rd_addr[1] = instrIF[14:10];
  assign rd_addr[2] = instrIF[19:15];
  assign rd_addr[3] = instrIF[4:0];

  // A NOP sitting in ID/EX writes nothing, so it never creates a hazard.
  assign id_nop     = (instructionID[24:23] == 2'b11) && (instructionID[22:15] == 8'd0);
  assign dest_valid = id_valid && !id_nop;
  assign dest       = instructionID[4:0];

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_val[p] = '0;
      if (wb_en && (rd_addr[p] == wb_addr)) begin
        rd_val[p] = wb_data;
      end else if (int'(rd_addr[p]) < NREGS) begin
        rd_val[p] = regs[rd_addr[p]];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      slot_hit[p] = slot_use[p] && dest_valid && (rd_addr[p] == dest);
    end
  end

  assign hazard_cnt = 3'(slot_hit[0]) + 3'(slot_hit[1]) + 3'(slot_hit[2]) + 3'(slot_hit[3]);
  assign stall      = (hazard_cnt >= 3'd2);
  assign instr_ready = !rst && !stall;
  assign accept      = instr_valid && instr_ready;

  // With exactly one hit the execute passthrough feeds that slot.
  always_comb begin
    fwd_sel = 3'd0;
    if (hazard_cnt == 3'd1) begin
      if (slot_hit[0])      fwd_sel = 3'd1;
      else if (slot_hit[1]) fwd_sel = 3'd2;
      else if (slot_hit[2]) fwd_sel = 3'd3;
      else                  fwd_sel = 3'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && (int'(wb_addr) < NREGS)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !accept) begin
      instructionID <= BUBBLE;
      rs1           <= '0;
      rs2           <= '0;
      rs3           <= '0;
      rd            <= '0;
      forward       <= 3'd0;
      id_valid      <= 1'b0;
    end else begin
      instructionID <= instrIF;
      rs1           <= rd_val[0];
      rs2           <= rd_val[1];
      rs3           <= rd_val[2];
      rd            <= rd_val[3];
      forward       <= fwd_sel;
      id_valid      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: reference model feeds an expected
// queue of ID/EX contents; directed scenarios plus a randomized run.
module tb_decode_stage;

  localparam int XLEN = 128;
  localparam int W    = 25 + 4 * XLEN + 3 + 1;
  localparam logic [24:0] BUBBLE = 25'h1800000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [24:0]     instrIF = BUBBLE;
  logic            wb_en = 1'b0;
  logic [4:0]      wb_addr = 5'd0;
  logic [XLEN-1:0] wb_data = '0;
  logic [24:0]     instructionID;
  logic [XLEN-1:0] rs1, rs2, rs3, rd;
  logic [2:0]      forward;
  logic            id_valid;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instrIF(instrIF),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .instructionID(instructionID), .rs1(rs1), .rs2(rs2), .rs3(rs3), .rd(rd),
    .forward(forward), .id_valid(id_valid)
  );

  logic [W-1:0]    exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [XLEN-1:0] m_regs [32];
  logic [24:0]     m_instr;
  logic            m_valid;
  logic            seen_ready;

  function automatic logic is_nop(input logic [24:0] i);
    return (i[24:23] == 2'b11) && (i[22:15] == 8'd0);
  endfunction

  function automatic logic [4:0] fld(input logic [24:0] i, input int k);
    case (k)
      0:       return i[9:5];
      1:       return i[14:10];
      2:       return i[19:15];
      default: return i[4:0];
    endcase
  endfunction

  // Read slots in use, bit order rs1, rs2, rs3, rd.
  function automatic logic [3:0] uses(input logic [24:0] i);
    if (!i[24]) return 4'b1000;
    if (!i[23]) return 4'b0111;
    if (is_nop(i)) return 4'b0000;
    return 4'b0011;
  endfunction

  function automatic logic [24:0] enc_r3(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {2'b11, op, 5'd0, s2, s1, d};
  endfunction

  function automatic logic [24:0] enc_r4(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3);
    return {2'b10, op, s3, s2, s1, d};
  endfunction

  function automatic logic [24:0] enc_li(input logic [2:0] idx, input logic [15:0] imm, input logic [4:0] d);
    return {1'b0, idx, imm, d};
  endfunction

  // One clock of stimulus: check instr_ready, predict ID/EX, compare after the edge.
  task automatic step(input logic r, input logic v, input logic [24:0] ins,
                      input logic we, input logic [4:0] wa, input logic [XLEN-1:0] wd);
    int              cnt;
    logic [2:0]      fsel;
    logic [2:0]      e_fwd;
    logic            e_ready;
    logic            e_valid;
    logic            dest_ok;
    logic [3:0]      u;
    logic [XLEN-1:0] ops [4];
    logic [24:0]     e_instr;
    logic [W-1:0]    got;
    logic [W-1:0]    exp;
    @(negedge clk);
    rst = r; instr_valid = v; instrIF = ins; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    u = uses(ins);
    dest_ok = m_valid && !is_nop(m_instr);
    cnt = 0;
    fsel = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (u[k] && dest_ok && (fld(ins, k) == m_instr[4:0])) begin
        cnt++;
        fsel = 3'(k + 1);
      end
    end
    e_ready = !r && (cnt < 2);
    seen_ready = instr_ready;
    n_checks++;
    if (instr_ready !== e_ready) begin
      n_fail++;
      $display("FAIL instr_ready: got %b expected %b (instr %h)", instr_ready, e_ready, ins);
    end
    for (int k = 0; k < 4; k++) begin
      ops[k] = (we && (fld(ins, k) == wa)) ? wd : m_regs[fld(ins, k)];
    end
    if (!r && v && e_ready) begin
      e_instr = ins;
      e_valid = 1'b1;
      e_fwd   = (cnt == 1) ? fsel : 3'd0;
    end else begin
      e_instr = BUBBLE;
      e_valid = 1'b0;
      e_fwd   = 3'd0;
      for (int k = 0; k < 4; k++) ops[k] = '0;
    end
    exp_q.push_back({e_instr, ops[0], ops[1], ops[2], ops[3], e_fwd, e_valid});
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else if (we) begin
      m_regs[wa] = wd;
    end
    m_instr = e_instr;
    m_valid = e_valid;
    @(posedge clk);
    #1;
    got = {instructionID, rs1, rs2, rs3, rd, forward, id_valid};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL id_ex: got %h expected %h", got, exp);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, BUBBLE, 1'b0, 5'd0, '0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, enc_r3(3'd1, 5'd1, 5'd1, 5'd1), 1'b1, 5'd1, 128'hff);
    n_checks++;
    if (instructionID !== BUBBLE || id_valid !== 1'b0 || forward !== 3'd0 || rs1 !== '0 || seen_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: instr %h valid %b fwd %0d ready %b, expected %h 0 0 0", instructionID, id_valid, forward, seen_ready, BUBBLE);
    end
    step(1'b0, 1'b1, enc_r3(3'd1, 5'd2, 5'd1, 5'd1), 1'b0, 5'd0, '0);
    n_checks++;
    if (rs1 !== '0 || id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_wb_ignored: rs1 %h valid %b, expected 0 and 1", rs1, id_valid);
    end
  endtask

  task automatic test_bypass();
    idle();
    step(1'b0, 1'b0, BUBBLE, 1'b1, 5'd3, 128'h5);
    step(1'b0, 1'b1, enc_r3(3'd1, 5'd4, 5'd3, 5'd3), 1'b0, 5'd0, '0);
    n_checks++;
    if (rs1 !== 128'h5 || rs2 !== 128'h5 || forward !== 3'd0) begin
      n_fail++;
      $display("FAIL regfile_read: rs1 %h rs2 %h fwd %0d, expected 5 5 0", rs1, rs2, forward);
    end
    step(1'b0, 1'b1, enc_r3(3'd2, 5'd4, 5'd6, 5'd6), 1'b1, 5'd6, 128'h9);
    n_checks++;
    if (rs1 !== 128'h9 || rs2 !== 128'h9 || forward !== 3'd0) begin
      n_fail++;
      $display("FAIL wb_bypass: rs1 %h rs2 %h fwd %0d, expected 9 9 0", rs1, rs2, forward);
    end
  endtask

  task automatic test_forward_rs2();
    idle();
    step(1'b0, 1'b1, enc_r3(3'd1, 5'd7, 5'd1, 5'd2), 1'b0, 5'd0, '0);
    step(1'b0, 1'b1, enc_r3(3'd1, 5'd8, 5'd1, 5'd7), 1'b0, 5'd0, '0);
    n_checks++;
    if (forward !== 3'd2 || id_valid !== 1'b1 || seen_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL forward_rs2: fwd %0d valid %b ready %b, expected 2 1 1", forward, id_valid, seen_ready);
    end
  endtask

  task automatic test_stall_r4();
    logic [24:0] x;
    x = enc_r4(3'd2, 5'd10, 5'd9, 5'd4, 5'd9);
    idle();
    step(1'b0, 1'b1, enc_r4(3'd1, 5'd9, 5'd1, 5'd2, 5'd3), 1'b0, 5'd0, '0);
    step(1'b0, 1'b1, x, 1'b0, 5'd0, '0);
    n_checks++;
    if (seen_ready !== 1'b0 || instructionID !== BUBBLE || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_bubble: ready %b instr %h valid %b, expected 0 %h 0", seen_ready, instructionID, id_valid, BUBBLE);
    end
    step(1'b0, 1'b1, x, 1'b1, 5'd9, 128'hdead_beef);
    n_checks++;
    if (seen_ready !== 1'b1 || forward !== 3'd0 || rs1 !== 128'hdead_beef || rs3 !== 128'hdead_beef || id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_reissue: ready %b fwd %0d rs1 %h rs3 %h valid %b, expected 1 0 deadbeef deadbeef 1", seen_ready, forward, rs1, rs3, id_valid);
    end
  endtask

  task automatic test_li();
    idle();
    step(1'b0, 1'b1, enc_li(3'd1, 16'h1234, 5'd2), 1'b0, 5'd0, '0);
    step(1'b0, 1'b1, enc_li(3'd2, 16'h5678, 5'd2), 1'b0, 5'd0, '0);
    n_checks++;
    if (forward !== 3'd4 || seen_ready !== 1'b1 || id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL li_forward_rd: fwd %0d ready %b valid %b, expected 4 1 1", forward, seen_ready, id_valid);
    end
  endtask

  task automatic test_nop();
    step(1'b0, 1'b0, BUBBLE, 1'b1, 5'd5, 128'h55);
    step(1'b0, 1'b1, enc_r3(3'd0, 5'd5, 5'd1, 5'd1), 1'b0, 5'd0, '0);
    step(1'b0, 1'b1, enc_r3(3'd1, 5'd11, 5'd5, 5'd1), 1'b0, 5'd0, '0);
    n_checks++;
    if (forward !== 3'd0 || rs1 !== 128'h55 || seen_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL nop_no_hazard: fwd %0d rs1 %h ready %b, expected 0 55 1", forward, rs1, seen_ready);
    end
  endtask

  task automatic test_reset_in_stall();
    logic [24:0] x;
    x = enc_r3(3'd1, 5'd12, 5'd10, 5'd10);
    idle();
    step(1'b0, 1'b1, enc_r3(3'd1, 5'd10, 5'd1, 5'd2), 1'b0, 5'd0, '0);
    step(1'b1, 1'b1, x, 1'b1, 5'd10, 128'h77);
    n_checks++;
    if (seen_ready !== 1'b0 || instructionID !== BUBBLE || id_valid !== 1'b0 || rs1 !== '0 || forward !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_in_stall: ready %b instr %h valid %b rs1 %h fwd %0d", seen_ready, instructionID, id_valid, rs1, forward);
    end
    step(1'b0, 1'b1, x, 1'b0, 5'd0, '0);
    n_checks++;
    if (seen_ready !== 1'b1 || id_valid !== 1'b1 || forward !== 3'd0 || rs1 !== '0 || instructionID !== x) begin
      n_fail++;
      $display("FAIL post_reset_issue: ready %b valid %b fwd %0d rs1 %h instr %h", seen_ready, id_valid, forward, rs1, instructionID);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] ins;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0:       ins = enc_li(3'($urandom_range(0, 7)), 16'($urandom), 5'($urandom_range(0, 7)));
        1:       ins = enc_r4(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        default: ins = enc_r3(3'($urandom_range(0, 2)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)));
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), ins,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_instr = BUBBLE;
    m_valid = 1'b0;
    seen_ready = 1'b0;
    test_reset();
    test_bypass();
    test_forward_rs2();
    test_stall_r4();
    test_li();
    test_nop();
    test_reset_in_stall();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, 128, register width in bits.
REQ-002 Parameter NREGS, 32, register-file depth, addressed by 5-bit fields.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; clock and reset are the only timing/reset ports.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 instr_valid  in  1  fetch presents instrIF.
REQ-007 instr_ready  out  1  combinational; instrIF accepted on edge when instr_valid&instr_ready.
REQ-008 instrIF  in  25  instruction word.
REQ-009 wb_en  in  1  writeback write strobe.
REQ-010 wb_addr  in  5  writeback destination.
REQ-011 wb_data  in  XLEN  writeback data.
REQ-012 instructionID  out  25  registered instruction to execute.
REQ-013 rs1, rs2, rs3, rd  out  XLEN each  registered operand values.
REQ-014 forward  out  3  registered select: 0 none, 1 rs1, 2 rs2, 3 rs3, 4 rd take execute passthrough.
REQ-015 id_valid  out  1  registered; ID/EX holds a real instruction.

Function
REQ-016 Decode: instr[24]=0 -> load-immediate (index [23:21], imm [20:5]), reads and writes field [4:0]; [24:23]=10 -> R4, reads [9:5],[14:10],[19:15], writes [4:0]; [24:23]=11 -> R3, reads [9:5],[14:10], writes [4:0].
REQ-017 R3 with [22:15]=0 SHALL be NOP: reads nothing, writes nothing.
REQ-018 BUBBLE = 25'h1800000 (R3 NOP).
REQ-019 Register file: NREGS x XLEN, one synchronous write port (wb_en/wb_addr/wb_data), four combinational read ports (fields [9:5],[14:10],[19:15],[4:0]).
REQ-020 Read bypass: a read port addressing wb_addr while wb_en=1 SHALL return wb_data in the same cycle.
REQ-021 In-flight destination = instructionID[4:0], valid only when id_valid=1 and instructionID is not NOP.
REQ-022 Hazard count = number of read slots (per REQ-016) whose field equals the valid in-flight destination; identical fields count separately.
REQ-023 Count 0 -> accept, forward=0.
REQ-024 Count 1 -> accept, forward = code of the matching slot (rs1=1, rs2=2, rs3=3, load-immediate rd=4).
REQ-025 Count >=2 -> instr_ready=0; ID/EX loads BUBBLE, id_valid=0, forward=0, operands 0; next cycle the in-flight destination is the bubble, count is 0, and bypass (REQ-020) supplies the value.
REQ-026 Stall SHALL last exactly one cycle per hazard.
REQ-027 instr_valid=0 while ready -> ID/EX loads BUBBLE, id_valid=0.
REQ-028 Accepted instruction: ID/EX loads instructionID=instrIF, operands from read ports, forward per REQ-023/024, id_valid=1; latency one cycle from accept.
REQ-029 instr_ready SHALL depend only on instrIF, instr_valid, and ID/EX state, never on wb_*.
REQ-030 Writeback writes are never blocked by stalls.

Reset
REQ-031 While rst=1 at an edge: instructionID=BUBBLE, rs1..rd=0, forward=0, id_valid=0, all registers=0.
REQ-032 instr_ready SHALL be 0 while rst=1; instrIF is not accepted and any pending stall is discarded.
REQ-033 wb writes in a reset cycle SHALL be ignored.

Verification
REQ-034 After reset, write r3=0x...0005 via wb; then R3 add rd=4, rs1=3, rs2=3 one cycle later -> rs1=rs2=5 (bypass), forward=0.
REQ-035 R3 writing r7, then R3 reading rs2=r7, rs1=r1 -> second issue forward=2, id_valid=1, no stall.
REQ-036 R4 writing r9, then R4 with rs1=r9, rs3=r9 -> one cycle instr_ready=0 with BUBBLE; next cycle issue with forward=0, rs1=rs3=wb_data of r9.
REQ-037 Load-immediate to r2, then load-immediate to r2 -> forward=4, no stall.
REQ-038 NOP "writing" r5, then reader of r5 -> forward=0, data from register file.
REQ-039 Assert rst during a stall cycle -> next cycle all outputs at reset values, instr_ready=0; after release the first instruction issues cleanly.
